// File: rtl/spi_transaction_fsm_if.sv
// Strobe/handshake bundle between the SPI input conditioners, the transaction
// FSM and the shift register / data memory datapath.
interface spi_transaction_fsm_if;
  logic       csb;
  logic       sclk_pos_edge;
  logic       sclk_neg_edge;
  logic       rw_bit;
  logic       addr_latch_en;
  logic       sr_load;
  logic       dm_write_en;
  logic       miso_buf_en;
  logic [2:0] state;

  modport master (
    output csb,
    output sclk_pos_edge,
    output sclk_neg_edge,
    output rw_bit,
    input  addr_latch_en,
    input  sr_load,
    input  dm_write_en,
    input  miso_buf_en,
    input  state
  );

  modport slave (
    input  csb,
    input  sclk_pos_edge,
    input  sclk_neg_edge,
    input  rw_bit,
    output addr_latch_en,
    output sr_load,
    output dm_write_en,
    output miso_buf_en,
    output state
  );
endinterface

// File: rtl/spi_transaction_fsm.sv
// Moore sequencer for one address/command byte plus one data byte per SPI frame.
// Optional build macro SPI_FSM_ABORT_EN: chip-select release aborts any transaction.
module spi_transaction_fsm #(
  parameter int unsigned Width = 8
) (
  input logic                   i_clk,
  input logic                   i_reset,
  spi_transaction_fsm_if.slave  io_bus
);

  localparam int unsigned CntW = $clog2(Width + 1);

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StAddr        = 3'd1;
  localparam logic [2:0] StDecode      = 3'd2;
  localparam logic [2:0] StReadLoad    = 3'd3;
  localparam logic [2:0] StReadShift   = 3'd4;
  localparam logic [2:0] StWriteShift  = 3'd5;
  localparam logic [2:0] StWriteCommit = 3'd6;
  localparam logic [2:0] StDone        = 3'd7;

  logic [2:0]      r_state;
  logic [2:0]      w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic [CntW-1:0] w_cnt_inc;
  logic            w_last;

  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_last    = (w_cnt_inc == CntW'(Width));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (!io_bus.csb) begin
          w_state_d = StAddr;
          w_cnt_d   = '0;
        end
      end
      StAddr: begin
        if (io_bus.sclk_pos_edge) begin
          w_cnt_d = w_cnt_inc;
          if (w_last) w_state_d = StDecode;
        end
      end
      StDecode: begin
        w_cnt_d   = '0;
        w_state_d = io_bus.rw_bit ? StReadLoad : StWriteShift;
      end
      StReadLoad: w_state_d = StReadShift;
      StReadShift: begin
        // Read data is shifted out on falling SCLK so the master samples on rising.
        if (io_bus.sclk_neg_edge) begin
          w_cnt_d = w_cnt_inc;
          if (w_last) w_state_d = StDone;
        end
      end
      StWriteShift: begin
        if (io_bus.sclk_pos_edge) begin
          w_cnt_d = w_cnt_inc;
          if (w_last) w_state_d = StWriteCommit;
        end
      end
      StWriteCommit: w_state_d = StDone;
      StDone: begin
        if (io_bus.csb) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
`ifdef SPI_FSM_ABORT_EN
    if (io_bus.csb && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign io_bus.addr_latch_en = (r_state == StDecode);
  assign io_bus.sr_load       = (r_state == StReadLoad);
  assign io_bus.miso_buf_en   = (r_state == StReadShift);
  assign io_bus.dm_write_en   = (r_state == StWriteCommit);
  assign io_bus.state         = r_state;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Directed bench for spi_transaction_fsm; honours SPI_FSM_ABORT_EN when defined.
module tb_spi_transaction_fsm;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;

  int tests = 0;
  int fails = 0;

  // Strobe-cycle counters, sampled once per clk
  int ale_cnt = 0;
  int srl_cnt = 0;
  int dmw_cnt = 0;
  int miso_cnt = 0;

  spi_transaction_fsm_if bus ();

  spi_transaction_fsm #(.Width(W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.addr_latch_en === 1'b1) ale_cnt++;
    if (bus.sr_load === 1'b1) srl_cnt++;
    if (bus.dm_write_en === 1'b1) dmw_cnt++;
    if (bus.miso_buf_en === 1'b1) miso_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Two quiet cycles, then a one-cycle pulse; returns one cycle after capture.
  task automatic send_edge(input logic p, input logic n);
    repeat (2) @(negedge clk);
    bus.sclk_pos_edge = p;
    bus.sclk_neg_edge = n;
    @(negedge clk);
    bus.sclk_pos_edge = 1'b0;
    bus.sclk_neg_edge = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.csb = 1'b1;
    bus.sclk_pos_edge = 1'b0;
    bus.sclk_neg_edge = 1'b0;
    bus.rw_bit = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d want 0", bus.state);
    end
    tests++;
    if ({bus.addr_latch_en, bus.sr_load, bus.dm_write_en, bus.miso_buf_en} !== 4'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000",
               {bus.addr_latch_en, bus.sr_load, bus.dm_write_en, bus.miso_buf_en});
    end
    send_edge(1'b1, 1'b1);
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL idle_ignores_edges: got %0d want 0", bus.state);
    end
  endtask

  task automatic test_write();
    int ale0, srl0, dmw0, miso0;
    logic [7:0] frame;
    frame = 8'h54;
    ale0 = ale_cnt; srl0 = srl_cnt; dmw0 = dmw_cnt; miso0 = miso_cnt;
    bus.rw_bit = frame[0];
    bus.csb = 1'b0;
    tick();
    tests++;
    if (bus.state !== 3'd1) begin
      fails++;
      $display("FAIL write_enter_addr: got %0d want 1", bus.state);
    end
    for (int i = 0; i < 8; i++) send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd2 || bus.addr_latch_en !== 1'b1) begin
      fails++;
      $display("FAIL write_decode: got state %0d ale %b want 2/1", bus.state, bus.addr_latch_en);
    end
    tick();
    tests++;
    if (bus.state !== 3'd5) begin
      fails++;
      $display("FAIL write_shift_entry: got %0d want 5", bus.state);
    end
    for (int i = 0; i < 7; i++) send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd5 || bus.dm_write_en !== 1'b0) begin
      fails++;
      $display("FAIL write_before_last: got state %0d dmw %b want 5/0", bus.state, bus.dm_write_en);
    end
    send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd6 || bus.dm_write_en !== 1'b1) begin
      fails++;
      $display("FAIL write_commit: got state %0d dmw %b want 6/1", bus.state, bus.dm_write_en);
    end
    tick();
    tests++;
    if (bus.state !== 3'd7 || bus.dm_write_en !== 1'b0) begin
      fails++;
      $display("FAIL write_done: got state %0d dmw %b want 7/0", bus.state, bus.dm_write_en);
    end
    send_edge(1'b1, 1'b1);
    tests++;
    if (bus.state !== 3'd7) begin
      fails++;
      $display("FAIL done_ignores_edges: got %0d want 7", bus.state);
    end
    bus.csb = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL write_back_idle: got %0d want 0", bus.state);
    end
    tests++;
    if (ale_cnt - ale0 != 1 || dmw_cnt - dmw0 != 1 || srl_cnt != srl0 || miso_cnt != miso0) begin
      fails++;
      $display("FAIL write_strobe_counts: got ale %0d dmw %0d srl %0d miso %0d want 1 1 0 0",
               ale_cnt - ale0, dmw_cnt - dmw0, srl_cnt - srl0, miso_cnt - miso0);
    end
  endtask

  // Read frame; both_edges drives pos+neg together on every pulse.
  task automatic run_read(input string tag, input logic both_edges);
    int dmw0, srl0;
    logic [7:0] frame;
    frame = 8'h55;
    dmw0 = dmw_cnt; srl0 = srl_cnt;
    bus.rw_bit = frame[0];
    bus.csb = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) send_edge(1'b1, both_edges);
    tests++;
    if (bus.state !== 3'd1) begin
      fails++;
      $display("FAIL %s_addr_7: got %0d want 1", tag, bus.state);
    end
    send_edge(1'b1, both_edges);
    tests++;
    if (bus.state !== 3'd2 || bus.addr_latch_en !== 1'b1) begin
      fails++;
      $display("FAIL %s_decode: got state %0d ale %b want 2/1", tag, bus.state, bus.addr_latch_en);
    end
    tick();
    tests++;
    if (bus.state !== 3'd3 || bus.sr_load !== 1'b1 || bus.addr_latch_en !== 1'b0) begin
      fails++;
      $display("FAIL %s_load: got state %0d srl %b want 3/1", tag, bus.state, bus.sr_load);
    end
    tick();
    tests++;
    if (bus.state !== 3'd4 || bus.miso_buf_en !== 1'b1 || bus.sr_load !== 1'b0) begin
      fails++;
      $display("FAIL %s_miso_on: got state %0d miso %b want 4/1", tag, bus.state, bus.miso_buf_en);
    end
    // Posedges alone must not advance the read shift
    if (!both_edges) begin
      send_edge(1'b1, 1'b0);
      send_edge(1'b1, 1'b0);
    end
    for (int i = 0; i < 7; i++) send_edge(both_edges, 1'b1);
    tests++;
    if (bus.state !== 3'd4 || bus.miso_buf_en !== 1'b1) begin
      fails++;
      $display("FAIL %s_miso_hold: got state %0d miso %b want 4/1", tag, bus.state,
               bus.miso_buf_en);
    end
    send_edge(both_edges, 1'b1);
    tests++;
    if (bus.state !== 3'd7 || bus.miso_buf_en !== 1'b0) begin
      fails++;
      $display("FAIL %s_miso_off: got state %0d miso %b want 7/0", tag, bus.state,
               bus.miso_buf_en);
    end
    tests++;
    if (dmw_cnt != dmw0 || srl_cnt - srl0 != 1) begin
      fails++;
      $display("FAIL %s_strobe_counts: got dmw %0d srl %0d want 0 1", tag, dmw_cnt - dmw0,
               srl_cnt - srl0);
    end
    bus.csb = 1'b1;
    tick();
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL %s_back_idle: got %0d want 0", tag, bus.state);
    end
  endtask

  task automatic test_read();
    run_read("read", 1'b0);
  endtask

  task automatic test_simultaneous();
    run_read("simul", 1'b1);
  endtask

  task automatic test_reset_mid();
    bus.rw_bit = 1'b0;
    bus.csb = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send_edge(1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd5) begin
      fails++;
      $display("FAIL rstmid_pre: got %0d want 5", bus.state);
    end
    reset = 1'b1;
    bus.csb = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (bus.state !== 3'd0 ||
        {bus.addr_latch_en, bus.sr_load, bus.dm_write_en, bus.miso_buf_en} !== 4'b0) begin
      fails++;
      $display("FAIL rstmid_idle: got state %0d want 0 with outputs low", bus.state);
    end
    for (int i = 0; i < 3; i++) send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL rstmid_ignore: got %0d want 0", bus.state);
    end
    bus.csb = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd1) begin
      fails++;
      $display("FAIL rstmid_cnt_cleared: got %0d want 1", bus.state);
    end
    send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd2) begin
      fails++;
      $display("FAIL rstmid_decode: got %0d want 2", bus.state);
    end
    reset = 1'b1;
    bus.csb = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_abort();
    int dmw0;
    dmw0 = dmw_cnt;
    bus.rw_bit = 1'b0;
    bus.csb = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send_edge(1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) send_edge(1'b1, 1'b0);
    bus.csb = 1'b1;
    tick();
`ifdef SPI_FSM_ABORT_EN
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL abort_idle: got %0d want 0", bus.state);
    end
    for (int i = 0; i < 4; i++) send_edge(1'b1, 1'b0);
    tick();
    tests++;
    if (dmw_cnt != dmw0 || bus.state !== 3'd0) begin
      fails++;
      $display("FAIL abort_no_write: got dmw %0d state %0d want 0/0", dmw_cnt - dmw0, bus.state);
    end
`else
    tests++;
    if (bus.state !== 3'd5) begin
      fails++;
      $display("FAIL noabort_hold: got %0d want 5", bus.state);
    end
    for (int i = 0; i < 4; i++) send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd6 || bus.dm_write_en !== 1'b1) begin
      fails++;
      $display("FAIL noabort_commit: got state %0d dmw %b want 6/1", bus.state, bus.dm_write_en);
    end
    tick();
    tick();
    tests++;
    if (dmw_cnt - dmw0 != 1 || bus.state !== 3'd0) begin
      fails++;
      $display("FAIL noabort_write_once: got dmw %0d state %0d want 1/0", dmw_cnt - dmw0,
               bus.state);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int dmw0, srl0;
    dmw0 = dmw_cnt; srl0 = srl_cnt;
    bus.rw_bit = 1'b0;
    bus.csb = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send_edge(1'b1, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) send_edge(1'b1, 1'b0);
    tick();
    bus.csb = 1'b1;
    tick();
    tests++;
    if (bus.state !== 3'd0) begin
      fails++;
      $display("FAIL b2b_gap_idle: got %0d want 0", bus.state);
    end
    bus.csb = 1'b0;
    bus.rw_bit = 1'b1;
    tick();
    tests++;
    if (bus.state !== 3'd1) begin
      fails++;
      $display("FAIL b2b_second_addr: got %0d want 1", bus.state);
    end
    for (int i = 0; i < 7; i++) send_edge(1'b1, 1'b0);
    tests++;
    if (bus.state !== 3'd1) begin
      fails++;
      $display("FAIL b2b_cnt_restart: got %0d want 1", bus.state);
    end
    send_edge(1'b1, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) send_edge(1'b0, 1'b1);
    tests++;
    if (bus.state !== 3'd7) begin
      fails++;
      $display("FAIL b2b_read_done: got %0d want 7", bus.state);
    end
    bus.csb = 1'b1;
    tick();
    tick();
    tests++;
    if (dmw_cnt - dmw0 != 1 || srl_cnt - srl0 != 1) begin
      fails++;
      $display("FAIL b2b_strobes: got dmw %0d srl %0d want 1 1", dmw_cnt - dmw0, srl_cnt - srl0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_transaction_fsm.md
# spi_transaction_fsm

Sequencing controller for the SPI memory slave datapath. It counts conditioned SCLK edge pulses while chip select is active and generates the strobes that drive the shift register, address latch, data memory and MISO tri-state buffer. Each transaction is one address/command byte (7-bit address plus R/W flag in bit 0) followed by one data byte, either read out of or written into data memory. The block sits between the input conditioners (synchronized CS and SCLK edge pulses) and the shift register / data memory pair.

## Interface
- `width`, default 8: bits per SPI frame; the counter is `$clog2(width+1)` bits wide.
- `clk` input 1: FPGA clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; forces the IDLE state and clears the bit counter.
- `csb` input 1: synchronized chip select, active low.
- `sclkPosEdge` input 1: single-`clk` pulse on each SCLK rising edge.
- `sclkNegEdge` input 1: single-`clk` pulse on each SCLK falling edge.
- `rwBit` input 1: shift register `parallelDataOut[0]`; 1 = read, 0 = write.
- `addrLatchEn` output 1: load the address latch from the shift register.
- `srLoad` output 1: drives the shift register `parallelLoad`.
- `dmWriteEn` output 1: data memory write enable.
- `misoBufEn` output 1: MISO tri-state buffer enable.
- `state` output 3: current state encoding, for debug.

## Operation
- Moore machine. Every output decodes from the registered state only.
- State encodings and asserted outputs:
  - IDLE = 0: none.
  - ADDR = 1: none.
  - DECODE = 2: `addrLatchEn`.
  - READ_LOAD = 3: `srLoad`.
  - READ_SHIFT = 4: `misoBufEn`.
  - WRITE_SHIFT = 5: none.
  - WRITE_COMMIT = 6: `dmWriteEn`.
  - DONE = 7: none.
- Transitions are evaluated each `clk`. `reset` has the highest priority.
  - IDLE: if `csb`==0, go to ADDR and clear the counter.
  - ADDR: increment the counter on each `sclkPosEdge`. Go to DECODE on the cycle the increment reaches `width`.
  - DECODE: stay one cycle and clear the counter. If `rwBit`==1, go to READ_LOAD; otherwise go to WRITE_SHIFT.
  - READ_LOAD: stay one cycle. Memory read data is valid here, one cycle after the address latch. Go to READ_SHIFT.
  - READ_SHIFT: increment the counter on each `sclkNegEdge`. At `width`, go to DONE.
  - WRITE_SHIFT: increment the counter on each `sclkPosEdge`. At `width`, go to WRITE_COMMIT.
  - WRITE_COMMIT: stay one cycle, then go to DONE.
  - DONE: stay until `csb`==1, then go to IDLE. Edges are ignored.
- Edge selection:
  - ADDR and WRITE_SHIFT count only `sclkPosEdge`.
  - READ_SHIFT counts only `sclkNegEdge`.
  - If both pulses are high in the same cycle, only the relevant one counts.
  - Edges in IDLE, DECODE, READ_LOAD, WRITE_COMMIT and DONE are ignored and do not change the counter.
- The counter never exceeds `width`. It is cleared on entry to ADDR and in DECODE.
- Output signal count per transaction:
  - `addrLatchEn`, `srLoad` and `dmWriteEn` each pulse at most once, for exactly one `clk`.
  - `srLoad` and `dmWriteEn` are never high in the same transaction.

## Timing
- Reset: on the first `clk` edge with `reset`=1, the block enters IDLE and every output is 0. `state` reads 0.
- `csb` falling to ADDR: 1 `clk`.
- `width`-th `sclkPosEdge` to `addrLatchEn` high: 1 `clk`.
- `addrLatchEn` to `srLoad`: 1 `clk`.
- `srLoad` to `misoBufEn`: 1 `clk`.
- `misoBufEn` stays high from READ_SHIFT entry until 1 `clk` after the `width`-th `sclkNegEdge`.
- Final data `sclkPosEdge` to `dmWriteEn` pulse: 1 `clk`.
- Minimum spacing between SCLK edge pulses is 3 `clk`. This guarantees DECODE and READ_LOAD complete before the next edge arrives.

## Configuration
- `SPI_FSM_ABORT_EN` defined:
  - `csb`==1 in any state other than IDLE forces IDLE on the next `clk` and clears the counter. This takes priority over the state's normal transition.
  - An abort that arrives while in WRITE_COMMIT still produces that cycle's `dmWriteEn` pulse, because outputs are Moore.
  - An abort before WRITE_COMMIT produces no memory write.
- `SPI_FSM_ABORT_EN` undefined:
  - `csb` is examined only in IDLE and DONE. A mid-transaction rise of `csb` is ignored, and the frame completes on subsequent edges.

## Test plan
- Reset mid-transfer: assert `reset` for one `clk` while in WRITE_SHIFT with counter=5 -> `state`=0, all outputs 0; later edges are ignored until `csb` falls.
- Write, `width`=8: `csb`=0, 8 posedges with frame 0x54 (`rwBit`=0), then 8 posedges -> `addrLatchEn` pulses once, then `dmWriteEn` pulses once 1 `clk` after the 16th posedge; `srLoad` and `misoBufEn` never assert; state reaches DONE, then IDLE after `csb`=1.
- Read: frame 0x55 (`rwBit`=1) -> sequence `addrLatchEn`, `srLoad`, `misoBufEn` on consecutive cycles; `misoBufEn` holds for 8 negedges and drops 1 `clk` after the 8th; `dmWriteEn` stays 0.
- Simultaneous pulses: in ADDR drive `sclkPosEdge`=`sclkNegEdge`=1 for 8 events -> DECODE entered after exactly 8; in READ_SHIFT the same stimulus counts negedges only.
- Abort with `SPI_FSM_ABORT_EN`: raise `csb` after 4 data posedges of a write -> IDLE next `clk`, `dmWriteEn` never asserts. Without the macro: the same stimulus plus 4 more posedges -> `dmWriteEn` pulses once.
- Back-to-back: two transactions, write then read, with `csb` high for one `clk` between them -> each completes independently and the counter restarts from 0.
